operand_fetch_unit: RTL and testbench
=====================================

# operand_fetch_unit

Parametrised addressing-mode sequencer for the CPU core. It fetches instruction operand bytes over the CPU bus, forms the effective address for the immediate, zero-page, zero-page-indexed and absolute(-indexed) modes, performs the data read, and returns the operand with its N/Z flags. Per-instruction decode sits in front of it; it owns the bus for the duration of one operand fetch and paces itself with its own `CLOCK_DIVIDER` tick.

## Interface
- `CLOCK_DIVIDER`, default 12: `clock_i` cycles per bus cycle (tick); legal range 1..256.
- `clock_i`  in  1  system clock; all state on rising edge.
- `reset_ni`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  request an operand fetch; sampled only on a tick while idle.
- `mode_i`  in  3  addressing mode: 0 IMM, 1 ZP, 2 ZPX, 3 ZPY, 4 ABS, 5 ABSX, 6 ABSY; 7 is reserved and behaves as IMM.
- `pc_i`  in  16  address of the first operand byte.
- `index_x_i`, `index_y_i`  in  8 each  index registers; latched at start.
- `data_i`  in  8  bus read data.
- `data_valid_i`  in  1  `data_i` valid for the current address.
- `address_o`  out  16  bus address.
- `address_valid_o`  out  1  a bus read is in progress.
- `busy_o`  out  1  fetch in progress (any non-IDLE state).
- `done_o`  out  1  one `clock_i`-cycle pulse; the fetch is complete.
- `operand_o`  out  8  fetched operand; held until the next `done_o`.
- `effective_address_o`  out  16  final read address (IMM: the operand address).
- `next_pc_o`  out  16  `pc_i` + operand length (1 or 2), wrapping mod 2^16.
- `page_cross_o`  out  1  the indexed absolute mode crossed a page.
- `zero_o`, `negative_o`  out  1 each  `operand_o == 0` and `operand_o[7]`.

## Operation
- The tick divider counts 0..CLOCK_DIVIDER-1. The tick is high for one `clock_i` cycle at wrap. The FSM advances only on ticks.
- States: IDLE, OPER_LO, OPER_HI, INDEX, FIX, READ.
- IDLE: when a tick arrives with `start_i`=1, latch mode, `pc_i` and the index registers. Then `address_o`<=`pc_i`, `address_valid_o`<=1, and go to OPER_LO.
- OPER_LO, capture the low byte `lo`:
  - IMM: finish with operand `lo`.
  - ZP: go to READ at {00,`lo`}.
  - ZPX/ZPY: go to INDEX at {00,`lo`}.
  - ABS*: go to OPER_HI at `pc+1`.
- OPER_HI: capture the high byte `hi`. Compute `sum` = `lo` + index (9 bits). `page_cross` = `sum[8]` for ABSX/ABSY, and 0 for all other modes.
  - If `page_cross` is set and `OFU_PAGE_PENALTY_EN` is defined: go to FIX at {`hi`, `sum[7:0]`}.
  - Otherwise: go to READ at {`hi`,`lo`} + index (16-bit).
- INDEX: a dummy read; `data_i` is ignored. Go to READ at {00, (`lo`+index) mod 256}. Zero-page indexing never leaves page 0.
- FIX: a dummy read. Go to READ at {`hi`+1, `sum[7:0]`}.
- READ: capture the operand and finish.
- A capturing state (OPER_LO, OPER_HI, READ) advances only on a tick with `data_valid_i`=1. Otherwise it holds state and `address_o` (wait state). INDEX and FIX advance on every tick.
- Finish, in the same edge:
  - `operand_o`, `effective_address_o`, `next_pc_o`, `page_cross_o` and the flags are updated.
  - `done_o`=1 for that one cycle.
  - `address_valid_o`<=0, `busy_o`<=0, and the FSM returns to IDLE.
- `start_i` while busy is ignored. No queueing.

## Timing
- Reset values: all outputs 0 (`address_o`=16'h0000); FSM IDLE; divider count 0.
- Latency in ticks, from the accept tick to the `done_o` tick, with no wait states:
  - IMM 1; ZP 2; ZPX/ZPY 3; ABS 3.
  - ABSX/ABSY: 3, or 4 on a page cross with the penalty enabled.
  - Each wait state adds 1.
- With `CLOCK_DIVIDER`=1, a tick occurs every cycle, so a new start may be accepted the cycle after `done_o`.
- `reset_ni` low mid-fetch: on the next edge all outputs take reset values, `done_o` is not asserted, and the bus is released.
- Address wrap: `pc+1` from 16'hFFFF is 16'h0000. ABS indexed from 16'hFFxx wraps to page 00.

## Configuration
- `OFU_PAGE_PENALTY_EN` defined: ABSX/ABSY with a page cross insert the FIX dummy read at the unfixed address, matching original 6502 bus behaviour.
- `OFU_PAGE_PENALTY_EN` undefined: FIX is never entered and the corrected address is read directly. `page_cross_o` is still reported.

## Test plan
- IMM, `CLOCK_DIVIDER`=1, `pc`=16'h0200, mem[0200]=8'h80 -> address 0200. `done_o` 1 tick after accept. `operand_o`=80, `negative_o`=1, `zero_o`=0, `next_pc_o`=0201.
- ZPX, operand F0, X=20, mem[0010]=00 -> addresses 0200, 00F0, 0010. `effective_address_o`=0010, `zero_o`=1, `page_cross_o`=0, 3 ticks.
- ABSY, bytes F0 12, Y=20:
  - Penalty on -> addresses 0200, 0201, 1210, 1310. 4 ticks, `page_cross_o`=1, `next_pc_o`=0202.
  - Penalty off -> 0200, 0201, 1310. 3 ticks.
- ABS with `data_valid_i` held low for 3 ticks in OPER_HI -> `address_o` stays 0201 and `done_o` arrives 6 ticks after accept. `start_i` pulsed during the fetch is ignored.
- `reset_ni` low during READ of ABS -> next edge: `busy_o`=0, `address_valid_o`=0, no `done_o`. A new IMM start afterwards completes normally.
- `CLOCK_DIVIDER`=12 -> ticks every 12 cycles, `address_o` changes only on tick edges, and ZP completes in 24 clocks from the accept tick.

Source files
------------

// File: rtl/operand_fetch_unit_if.sv
// CPU-bus and request/result bundle for operand_fetch_unit.
// master = requester/bus model side, slave = the sequencer.
interface operand_fetch_unit_if;
   logic        start_i;
   logic [2:0]  mode_i;
   logic [15:0] pc_i;
   logic [7:0]  index_x_i;
   logic [7:0]  index_y_i;
   logic [7:0]  data_i;
   logic        data_valid_i;
   logic [15:0] address_o;
   logic        address_valid_o;
   logic        busy_o;
   logic        done_o;
   logic [7:0]  operand_o;
   logic [15:0] effective_address_o;
   logic [15:0] next_pc_o;
   logic        page_cross_o;
   logic        zero_o;
   logic        negative_o;

   modport master (
      output start_i, mode_i, pc_i, index_x_i, index_y_i, data_i, data_valid_i,
      input  address_o, address_valid_o, busy_o, done_o, operand_o,
             effective_address_o, next_pc_o, page_cross_o, zero_o, negative_o
   );

   modport slave (
      input  start_i, mode_i, pc_i, index_x_i, index_y_i, data_i, data_valid_i,
      output address_o, address_valid_o, busy_o, done_o, operand_o,
             effective_address_o, next_pc_o, page_cross_o, zero_o, negative_o
   );
endinterface

// File: rtl/operand_fetch_unit.sv
// Addressing-mode sequencer: fetches operand bytes, forms the effective address, reads the operand.
// Optional OFU_PAGE_PENALTY_EN inserts the 6502-style dummy read on an indexed-absolute page cross.
module operand_fetch_unit #(
   parameter int CLOCK_DIVIDER = 12
) (
   input  logic               clock_i,
   input  logic               reset_ni,
   operand_fetch_unit_if.slave bus
);

   localparam int CNT_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCK_DIVIDER - 1);

   localparam logic [2:0] M_IMM  = 3'd0;
   localparam logic [2:0] M_ZP   = 3'd1;
   localparam logic [2:0] M_ZPX  = 3'd2;
   localparam logic [2:0] M_ZPY  = 3'd3;
   localparam logic [2:0] M_ABS  = 3'd4;
   localparam logic [2:0] M_ABSX = 3'd5;
   localparam logic [2:0] M_ABSY = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE, S_OPER_LO, S_OPER_HI, S_INDEX, S_FIX, S_READ
   } state_t;

   function automatic logic is_abs(input logic [2:0] m);
      return (m == M_ABS) || (m == M_ABSX) || (m == M_ABSY);
   endfunction

   function automatic logic [7:0] index_sel(input logic [2:0] m,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
      if (m == M_ZPX || m == M_ABSX) return x;
      if (m == M_ZPY || m == M_ABSY) return y;
      return 8'h00;
   endfunction

   logic [CNT_W-1:0] div_cnt;
   logic             tick;
   state_t           state;
   logic [2:0]       mode_q;
   logic             pcross_q;
   logic [15:0]      pc_q;
   logic [7:0]       lo_q;
   logic [7:0]       idx_q;
   logic [8:0]       sum;
   logic             crossed;

   assign tick    = (div_cnt == CNT_MAX);
   assign sum     = {1'b0, lo_q} + {1'b0, idx_q};
   assign crossed = sum[8] && (mode_q == M_ABSX || mode_q == M_ABSY);

   always_ff @(posedge clock_i) begin
      if (!reset_ni || tick) div_cnt <= '0;
      else                   div_cnt <= div_cnt + 1'b1;
   end

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         state                   <= S_IDLE;
         mode_q                  <= M_IMM;
         pcross_q                <= 1'b0;
         bus.address_o           <= '0;
         bus.address_valid_o     <= 1'b0;
         bus.busy_o              <= 1'b0;
         bus.done_o              <= 1'b0;
         bus.operand_o           <= '0;
         bus.effective_address_o <= '0;
         bus.next_pc_o           <= '0;
         bus.page_cross_o        <= 1'b0;
         bus.zero_o              <= 1'b0;
         bus.negative_o          <= 1'b0;
      end else begin
         bus.done_o <= 1'b0;
         if (tick) begin
            unique case (state)
               S_IDLE: begin
                  if (bus.start_i) begin
                     mode_q              <= bus.mode_i;
                     pc_q                <= bus.pc_i;
                     idx_q               <= index_sel(bus.mode_i, bus.index_x_i, bus.index_y_i);
                     pcross_q            <= 1'b0;
                     bus.address_o       <= bus.pc_i;
                     bus.address_valid_o <= 1'b1;
                     bus.busy_o          <= 1'b1;
                     state               <= S_OPER_LO;
                  end
               end
               S_OPER_LO: begin
                  if (bus.data_valid_i) begin
                     lo_q <= bus.data_i;
                     if (mode_q == M_ZP) begin
                        bus.address_o <= {8'h00, bus.data_i};
                        state         <= S_READ;
                     end else if (mode_q == M_ZPX || mode_q == M_ZPY) begin
                        bus.address_o <= {8'h00, bus.data_i};
                        state         <= S_INDEX;
                     end else if (is_abs(mode_q)) begin
                        bus.address_o <= pc_q + 16'd1;
                        state         <= S_OPER_HI;
                     end else begin
                        // IMM and the reserved mode finish on the first byte
                        bus.operand_o           <= bus.data_i;
                        bus.effective_address_o <= pc_q;
                        bus.next_pc_o           <= pc_q + 16'd1;
                        bus.page_cross_o        <= 1'b0;
                        bus.zero_o              <= (bus.data_i == 8'h00);
                        bus.negative_o          <= bus.data_i[7];
                        bus.done_o              <= 1'b1;
                        bus.address_valid_o     <= 1'b0;
                        bus.busy_o              <= 1'b0;
                        state                   <= S_IDLE;
                     end
                  end
               end
               S_OPER_HI: begin
                  if (bus.data_valid_i) begin
                     pcross_q <= crossed;
`ifdef OFU_PAGE_PENALTY_EN
                     if (crossed) begin
                        bus.address_o <= {bus.data_i, sum[7:0]};
                        state         <= S_FIX;
                     end else begin
                        bus.address_o <= {bus.data_i, lo_q} + {8'h00, idx_q};
                        state         <= S_READ;
                     end
`else
                     bus.address_o <= {bus.data_i, lo_q} + {8'h00, idx_q};
                     state         <= S_READ;
`endif
                  end
               end
               S_INDEX: begin
                  bus.address_o <= {8'h00, sum[7:0]};
                  state         <= S_READ;
               end
               S_FIX: begin
                  // bumping the high byte wraps page FF to page 00
                  bus.address_o <= bus.address_o + 16'h0100;
                  state         <= S_READ;
               end
               S_READ: begin
                  if (bus.data_valid_i) begin
                     bus.operand_o           <= bus.data_i;
                     bus.effective_address_o <= bus.address_o;
                     bus.next_pc_o           <= pc_q + (is_abs(mode_q) ? 16'd2 : 16'd1);
                     bus.page_cross_o        <= pcross_q;
                     bus.zero_o              <= (bus.data_i == 8'h00);
                     bus.negative_o          <= bus.data_i[7];
                     bus.done_o              <= 1'b1;
                     bus.address_valid_o     <= 1'b0;
                     bus.busy_o              <= 1'b0;
                     state                   <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit: one instance at CLOCK_DIVIDER=1, one at 12, sharing a memory.
module tb_operand_fetch_unit;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bit [7:0] mem [0:65535];

   operand_fetch_unit_if if1 ();
   operand_fetch_unit_if if12 ();

   assign if1.data_i  = mem[if1.address_o];
   assign if12.data_i = mem[if12.address_o];

   operand_fetch_unit #(.CLOCK_DIVIDER(1)) dut1 (
      .clock_i(clk), .reset_ni(reset_n), .bus(if1.slave)
   );
   operand_fetch_unit #(.CLOCK_DIVIDER(12)) dut12 (
      .clock_i(clk), .reset_ni(reset_n), .bus(if12.slave)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] addrs [$];
   int ticks;
   int cyc;
   logic [15:0] a11, a12;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_addrs(input string tag, input int n,
                              input logic [15:0] e0, e1, e2, e3);
      logic [15:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      check({tag, "_naddr"}, addrs.size(), n);
      for (int i = 0; i < n; i++)
         check($sformatf("%s_addr%0d", tag, i), (i < addrs.size()) ? addrs[i] : 16'hxxxx, e[i]);
   endtask

   // Accepts a fetch on the next edge and runs it to done_o, logging each new bus address.
   task automatic do_fetch(input string tag, input logic [2:0] m, input logic [15:0] pc,
                           input logic [7:0] x, input logic [7:0] y, output int t);
      @(negedge clk);
      if1.start_i = 1'b1; if1.mode_i = m; if1.pc_i = pc;
      if1.index_x_i = x; if1.index_y_i = y;
      @(posedge clk); #1;
      if1.start_i = 1'b0;
      check({tag, "_busy"}, if1.busy_o, 1'b1);
      addrs.delete();
      addrs.push_back(if1.address_o);
      t = 0;
      while (!if1.done_o && t < 60) begin
         @(posedge clk); #1;
         t++;
         if (if1.address_valid_o && if1.address_o != addrs[$]) addrs.push_back(if1.address_o);
      end
      check({tag, "_done"}, if1.done_o, 1'b1);
   endtask

   initial begin
      if1.start_i = 0; if1.mode_i = 0; if1.pc_i = 0; if1.index_x_i = 0; if1.index_y_i = 0;
      if1.data_valid_i = 1;
      if12.start_i = 0; if12.mode_i = 0; if12.pc_i = 0; if12.index_x_i = 0; if12.index_y_i = 0;
      if12.data_valid_i = 1;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_addr", if1.address_o, 16'h0000);
      check("rst_avalid", if1.address_valid_o, 1'b0);
      check("rst_busy", if1.busy_o, 1'b0);
      check("rst_done", if1.done_o, 1'b0);
      check("rst_operand", if1.operand_o, 8'h00);
      check("rst_ea", if1.effective_address_o, 16'h0000);
      check("rst_npc", if1.next_pc_o, 16'h0000);
      check("rst_flags", {if1.page_cross_o, if1.zero_o, if1.negative_o}, 3'b000);
      check("rst12_busy", if12.busy_o, 1'b0);
      @(negedge clk); reset_n = 1'b1;

      // IMM
      mem[16'h0200] = 8'h80;
      do_fetch("imm", 3'd0, 16'h0200, 8'h00, 8'h00, ticks);
      check("imm_ticks", ticks, 1);
      check("imm_operand", if1.operand_o, 8'h80);
      check("imm_neg", if1.negative_o, 1'b1);
      check("imm_zero", if1.zero_o, 1'b0);
      check("imm_npc", if1.next_pc_o, 16'h0201);
      check("imm_ea", if1.effective_address_o, 16'h0200);
      check_addrs("imm", 1, 16'h0200, 0, 0, 0);
      @(posedge clk); #1;
      check("imm_done_pulse", if1.done_o, 1'b0);

      // ZPX with zero-page wrap
      mem[16'h0200] = 8'hF0; mem[16'h0010] = 8'h00; mem[16'h0110] = 8'h99;
      do_fetch("zpx", 3'd2, 16'h0200, 8'h20, 8'h00, ticks);
      check("zpx_ticks", ticks, 3);
      check("zpx_ea", if1.effective_address_o, 16'h0010);
      check("zpx_zero", if1.zero_o, 1'b1);
      check("zpx_pcross", if1.page_cross_o, 1'b0);
      check("zpx_npc", if1.next_pc_o, 16'h0201);
      check_addrs("zpx", 3, 16'h0200, 16'h00F0, 16'h0010, 0);

      // ABSY page cross
      mem[16'h0200] = 8'hF0; mem[16'h0201] = 8'h12;
      mem[16'h1210] = 8'h11; mem[16'h1310] = 8'h5A;
      do_fetch("absy", 3'd6, 16'h0200, 8'h00, 8'h20, ticks);
`ifdef OFU_PAGE_PENALTY_EN
      check("absy_ticks", ticks, 4);
      check_addrs("absy", 4, 16'h0200, 16'h0201, 16'h1210, 16'h1310);
`else
      check("absy_ticks", ticks, 3);
      check_addrs("absy", 3, 16'h0200, 16'h0201, 16'h1310, 0);
`endif
      check("absy_pcross", if1.page_cross_o, 1'b1);
      check("absy_npc", if1.next_pc_o, 16'h0202);
      check("absy_operand", if1.operand_o, 8'h5A);
      check("absy_ea", if1.effective_address_o, 16'h1310);

      // ABSX wrapping from page FF to page 00, pc+1 wrapping to 0000
      mem[16'hFFFF] = 8'hF0; mem[16'h0000] = 8'hFF; mem[16'h0010] = 8'h3C; mem[16'hFF10] = 8'h77;
      do_fetch("wrap", 3'd5, 16'hFFFF, 8'h20, 8'h00, ticks);
`ifdef OFU_PAGE_PENALTY_EN
      check("wrap_ticks", ticks, 4);
      check_addrs("wrap", 4, 16'hFFFF, 16'h0000, 16'hFF10, 16'h0010);
`else
      check("wrap_ticks", ticks, 3);
      check_addrs("wrap", 3, 16'hFFFF, 16'h0000, 16'h0010, 0);
`endif
      check("wrap_operand", if1.operand_o, 8'h3C);
      check("wrap_npc", if1.next_pc_o, 16'h0001);
      check("wrap_pcross", if1.page_cross_o, 1'b1);

      // ABS with three wait states in OPER_HI and a stray start pulse
      mem[16'h0200] = 8'h34; mem[16'h0201] = 8'h12; mem[16'h1234] = 8'h7F;
      @(negedge clk);
      if1.start_i = 1'b1; if1.mode_i = 3'd4; if1.pc_i = 16'h0200;
      @(posedge clk); #1;
      if1.start_i = 1'b0;
      ticks = 0;
      @(posedge clk); #1; ticks++;
      check("wait_addr_hi", if1.address_o, 16'h0201);
      if1.data_valid_i = 1'b0;
      if1.start_i = 1'b1; if1.mode_i = 3'd0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1; ticks++;
         if1.start_i = 1'b0;
         check($sformatf("wait_hold%0d", i), if1.address_o, 16'h0201);
         check($sformatf("wait_busy%0d", i), {if1.busy_o, if1.done_o}, 2'b10);
      end
      if1.data_valid_i = 1'b1;
      while (!if1.done_o && ticks < 60) begin
         @(posedge clk); #1; ticks++;
      end
      check("wait_ticks", ticks, 6);
      check("wait_operand", if1.operand_o, 8'h7F);
      check("wait_ea", if1.effective_address_o, 16'h1234);
      check("wait_npc", if1.next_pc_o, 16'h0202);
      check("wait_pcross", if1.page_cross_o, 1'b0);
      @(posedge clk); #1;
      check("wait_idle_after", {if1.busy_o, if1.address_valid_o}, 2'b00);

      // reset during READ of ABS
      @(negedge clk);
      if1.start_i = 1'b1; if1.mode_i = 3'd4; if1.pc_i = 16'h0200;
      @(posedge clk); #1;
      if1.start_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rstmid_in_read", if1.address_o, 16'h1234);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("rstmid_busy", if1.busy_o, 1'b0);
      check("rstmid_avalid", if1.address_valid_o, 1'b0);
      check("rstmid_done", if1.done_o, 1'b0);
      check("rstmid_addr", if1.address_o, 16'h0000);
      @(negedge clk); reset_n = 1'b1;
      do_fetch("post_rst", 3'd0, 16'h0200, 8'h00, 8'h00, ticks);
      check("post_rst_ticks", ticks, 1);
      check("post_rst_operand", if1.operand_o, 8'h34);

      // CLOCK_DIVIDER=12: ZP completes 24 clocks after the accept tick
      mem[16'h0300] = 8'h44; mem[16'h0044] = 8'h81;
      @(negedge clk);
      if12.start_i = 1'b1; if12.mode_i = 3'd1; if12.pc_i = 16'h0300;
      cyc = 0;
      while (!if12.busy_o && cyc < 40) begin
         @(posedge clk); #1; cyc++;
      end
      check("div12_accept", if12.busy_o, 1'b1);
      if12.start_i = 1'b0;
      cyc = 0; a11 = 16'h0; a12 = 16'h0;
      while (!if12.done_o && cyc < 100) begin
         @(posedge clk); #1; cyc++;
         if (cyc == 11) a11 = if12.address_o;
         if (cyc == 12) a12 = if12.address_o;
      end
      check("div12_cycles", cyc, 24);
      check("div12_addr_before_tick", a11, 16'h0300);
      check("div12_addr_at_tick", a12, 16'h0044);
      check("div12_operand", if12.operand_o, 8'h81);
      check("div12_neg", if12.negative_o, 1'b1);
      check("div12_ea", if12.effective_address_o, 16'h0044);
      check("div12_npc", if12.next_pc_o, 16'h0301);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
